window_assembler: RTL and testbench

Parametrised successor to the LSH input handler. It accepts a stream of 2-bit nucleotides, several bases per beat, and assembles them into WINDOW_SIZE-base windows, which can overlap by a configurable stride. Each complete window is presented to the hashing stage with a sequence-local window ID and the insert/query mode. The window is held stable until the hasher reports completion. The block sits between the sequence reader and the LSH hashing core.

---
 rtl/window_assembler_pkg.sv | 25 ++
 rtl/window_assembler_if.sv | 36 +++
 rtl/window_assembler_shift_reg.sv | 41 ++++
 rtl/window_assembler.sv | 123 ++++++++++++
 tb/tb_window_assembler.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/window_assembler_pkg.sv
`default_nettype none
// ============================================================================
// lsh_pkg : base encoding, assembler FSM states and default LSH sizes
// Revision: 1.0
// ============================================================================
package lsh_pkg;

  typedef enum logic [1:0] {
    BASE_A = 2'b00,
    BASE_C = 2'b01,
    BASE_G = 2'b10,
    BASE_T = 2'b11
  } base_t;

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } assembler_state_t;

  localparam int DEFAULT_WINDOW_SIZE = 128;
  localparam int DEFAULT_KMER_SIZE   = 16;
  localparam int DEFAULT_LANES       = 4;

endpackage
`default_nettype wire

// File: rtl/window_assembler_if.sv
`default_nettype none
// ============================================================================
// window_assembler_if : base stream in, window + handshake out to the hasher
// Revision: 1.0
// ============================================================================
interface window_assembler_if
  import lsh_pkg::*;
#(
  parameter int WINDOW_SIZE = DEFAULT_WINDOW_SIZE,
  parameter int LANES       = DEFAULT_LANES,
  parameter int ID_WIDTH    = 16
);
  logic                         in_valid;
  logic                         in_ready;
  logic [LANES-1:0][1:0]        in_bases;
  logic                         in_seq_start;
  logic                         in_last;
  logic                         in_is_insert;
  logic [WINDOW_SIZE-1:0][1:0]  window;
  logic [ID_WIDTH-1:0]          window_id;
  logic                         window_reset;
  logic                         is_insert;
  logic                         ready_for_hashing;
  logic                         hashing_is_done;

  modport master (
    output in_valid, in_bases, in_seq_start, in_last, in_is_insert, hashing_is_done,
    input  in_ready, window, window_id, window_reset, is_insert, ready_for_hashing
  );

  modport slave (
    input  in_valid, in_bases, in_seq_start, in_last, in_is_insert, hashing_is_done,
    output in_ready, window, window_id, window_reset, is_insert, ready_for_hashing
  );
endinterface
`default_nettype wire

// File: rtl/window_assembler_shift_reg.sv
`default_nettype none
// ============================================================================
// window_shift_reg : LANES-wide shift register, new lanes enter at the top
// Revision: 1.0
// ============================================================================
module window_shift_reg
  import lsh_pkg::*;
#(
  parameter int WINDOW_SIZE = DEFAULT_WINDOW_SIZE,
  parameter int LANES       = DEFAULT_LANES
) (
  input  wire logic                        clk,
  input  wire logic                        rst_n,
  input  wire logic                        load_en,
  input  wire logic [LANES-1:0][1:0]       lanes,
  output logic      [WINDOW_SIZE-1:0][1:0] window
);

  logic [WINDOW_SIZE-1:0][1:0] window_q;
  logic [WINDOW_SIZE-1:0][1:0] window_d;

  // Lane 0 lands at WINDOW_SIZE-LANES so index 0 always holds the oldest base.
  always_comb begin
    window_d = window_q;
    if (load_en) begin
      window_d = {lanes, window_q[WINDOW_SIZE-1:LANES]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window_q <= '0;
    end else begin
      window_q <= window_d;
    end
  end

  assign window = window_q;

endmodule
`default_nettype wire

// File: rtl/window_assembler.sv
`default_nettype none
// ============================================================================
// window_assembler : builds WINDOW_SIZE-base windows for the LSH hasher.
// Optional overlap between windows: define WINDOW_ASSEMBLER_OVERLAP_EN.
// Revision: 1.0
// ============================================================================
module window_assembler
  import lsh_pkg::*;
#(
  parameter int WINDOW_SIZE = DEFAULT_WINDOW_SIZE,
  parameter int LANES       = DEFAULT_LANES,
  parameter int STRIDE      = 64,
  parameter int ID_WIDTH    = 16
) (
  input wire logic          clk,
  input wire logic          rst_n,
  window_assembler_if.slave bus
);

  localparam int CNT_W = $clog2(WINDOW_SIZE + 1);
  localparam logic [CNT_W-1:0] c_full   = CNT_W'(WINDOW_SIZE);
  localparam logic [CNT_W-1:0] c_lanes  = CNT_W'(LANES);
  localparam logic [CNT_W-1:0] c_retain = CNT_W'(WINDOW_SIZE - STRIDE);
`ifdef WINDOW_ASSEMBLER_OVERLAP_EN
  localparam bit c_overlap = 1'b1;
`else
  localparam bit c_overlap = 1'b0;
`endif

  assembler_state_t    state_q, state_d;
  logic [CNT_W-1:0]    fill_cnt_q, fill_cnt_d;
  logic [CNT_W-1:0]    fill_next;
  logic [ID_WIDTH-1:0] window_id_q, window_id_d;
  logic                is_insert_q, is_insert_d;
  logic                window_reset_q, window_reset_d;
  logic                rfh_q, rfh_d;
  logic                last_q, last_d;
  logic                accept;

  always_comb begin
    state_d        = state_q;
    fill_cnt_d     = fill_cnt_q;
    window_id_d    = window_id_q;
    is_insert_d    = is_insert_q;
    last_d         = last_q;
    window_reset_d = 1'b0;
    fill_next      = '0;
    accept         = 1'b0;

    case (state_q)
      ST_FILL: begin
        accept = bus.in_valid;
        if (accept) begin
          fill_next = (bus.in_seq_start ? '0 : fill_cnt_q) + c_lanes;
          if (bus.in_seq_start) begin
            window_id_d    = '0;
            is_insert_d    = bus.in_is_insert;
            window_reset_d = 1'b1;
          end
          if (fill_next == c_full) begin
            state_d    = ST_HOLD;
            fill_cnt_d = fill_next;
            last_d     = bus.in_last;
          end else if (bus.in_last) begin
            fill_cnt_d = '0;
          end else begin
            fill_cnt_d = fill_next;
          end
        end
      end
      ST_HOLD: begin
        if (bus.hashing_is_done) begin
          state_d     = ST_FILL;
          window_id_d = window_id_q + 1'b1;
          // A sequence that ended on this window has nothing left to overlap with.
          fill_cnt_d  = (c_overlap && !last_q) ? c_retain : '0;
        end
      end
      default: state_d = ST_FILL;
    endcase

    rfh_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_FILL;
      fill_cnt_q     <= '0;
      window_id_q    <= '0;
      is_insert_q    <= 1'b0;
      window_reset_q <= 1'b0;
      rfh_q          <= 1'b0;
      last_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      fill_cnt_q     <= fill_cnt_d;
      window_id_q    <= window_id_d;
      is_insert_q    <= is_insert_d;
      window_reset_q <= window_reset_d;
      rfh_q          <= rfh_d;
      last_q         <= last_d;
    end
  end

  window_shift_reg #(
    .WINDOW_SIZE (WINDOW_SIZE),
    .LANES       (LANES)
  ) u_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_en (accept),
    .lanes   (bus.in_bases),
    .window  (bus.window)
  );

  assign bus.in_ready          = (state_q == ST_FILL);
  assign bus.ready_for_hashing = rfh_q;
  assign bus.window_id         = window_id_q;
  assign bus.window_reset      = window_reset_q;
  assign bus.is_insert         = is_insert_q;

endmodule
`default_nettype wire

// File: tb/tb_window_assembler.sv
`default_nettype none
// ============================================================================
// tb_window_assembler : scoreboard bench for window_assembler
// Revision: 1.0
// ============================================================================
module tb_window_assembler;
  import lsh_pkg::*;

  localparam int WS = 128;
  localparam int LN = 4;
`ifdef WINDOW_ASSEMBLER_OVERLAP_EN
  localparam int RETAIN = 64;
`else
  localparam int RETAIN = 0;
`endif
  localparam int NEXT_BEATS = (WS - RETAIN) / LN;

  typedef logic [WS-1:0][1:0] win_t;
  typedef logic [LN-1:0][1:0] beat_t;
  typedef struct {
    win_t        w;
    logic [15:0] id;
    logic        ins;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  window_assembler_if #(.WINDOW_SIZE(WS), .LANES(LN), .ID_WIDTH(16)) bus ();
  window_assembler_if #(.WINDOW_SIZE(WS), .LANES(LN), .ID_WIDTH(2))  bus2 ();

  window_assembler #(.WINDOW_SIZE(WS), .LANES(LN), .STRIDE(64), .ID_WIDTH(16)) dut (
    .clk (clk), .rst_n (rst_n), .bus (bus)
  );
  window_assembler #(.WINDOW_SIZE(WS), .LANES(LN), .STRIDE(64), .ID_WIDTH(2)) dut2 (
    .clk (clk), .rst_n (rst_n), .bus (bus2)
  );

  int          tests = 0;
  int          fails = 0;
  exp_t        exp_q[$];
  win_t        m_win;
  int          m_cnt;
  logic [15:0] m_id;
  logic        m_ins;
  logic        m_last;
  beat_t       acgt;

  task automatic model_accept(input beat_t b, input logic ss, input logic last, input logic ins);
    exp_t e;
    if (ss) begin
      m_cnt = 0;
      m_id  = '0;
      m_ins = ins;
    end
    m_win = {b, m_win[WS-1:LN]};
    m_cnt = m_cnt + LN;
    if (m_cnt == WS) begin
      e.w = m_win; e.id = m_id; e.ins = m_ins;
      exp_q.push_back(e);
      m_last = last;
    end else if (last) begin
      m_cnt = 0;
    end
  endtask

  task automatic send_beat(input beat_t b, input logic ss, input logic last, input logic ins);
    int guard;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 50) begin
      tests++; fails++;
      $display("FAIL beat_wait in_ready=%b required 1", bus.in_ready);
    end
    bus.in_valid = 1'b1; bus.in_bases = b; bus.in_seq_start = ss;
    bus.in_last = last; bus.in_is_insert = ins;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_seq_start = 1'b0; bus.in_last = 1'b0;
    model_accept(b, ss, last, ins);
  endtask

  task automatic check_window(input string tag);
    exp_t e;
    tests++;
    if (bus.ready_for_hashing !== 1'b1) begin
      fails++; $display("FAIL %s_rfh got %b required 1", tag, bus.ready_for_hashing);
    end
    tests++;
    if (exp_q.size() == 0) begin
      fails++; $display("FAIL %s_sb_empty got 0 entries required 1", tag);
      return;
    end
    e = exp_q.pop_front();
    tests++;
    if (bus.window !== e.w) begin
      fails++; $display("FAIL %s_window got %h required %h", tag, bus.window, e.w);
    end
    tests++;
    if (bus.window_id !== e.id) begin
      fails++; $display("FAIL %s_id got %0d required %0d", tag, bus.window_id, e.id);
    end
    tests++;
    if (bus.is_insert !== e.ins) begin
      fails++; $display("FAIL %s_ins got %b required %b", tag, bus.is_insert, e.ins);
    end
  endtask

  task automatic hash_done(input string tag);
    bus.hashing_is_done = 1'b1;
    @(posedge clk); #1;
    bus.hashing_is_done = 1'b0;
    m_id++;
    m_cnt = m_last ? 0 : RETAIN;
    tests++;
    if (bus.ready_for_hashing !== 1'b0) begin
      fails++; $display("FAIL %s_done_rfh got %b required 0", tag, bus.ready_for_hashing);
    end
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL %s_done_ready got %b required 1", tag, bus.in_ready);
    end
    tests++;
    if (bus.window_id !== m_id) begin
      fails++; $display("FAIL %s_done_id got %0d required %0d", tag, bus.window_id, m_id);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    tests++;
    if (bus.in_ready !== 1'b1 || bus.ready_for_hashing !== 1'b0 || bus.window_reset !== 1'b0 ||
        bus.is_insert !== 1'b0 || bus.window_id !== 16'd0) begin
      fails++;
      $display("FAIL %s_ctrl got rdy=%b rfh=%b wr=%b ins=%b id=%0d required 1 0 0 0 0", tag,
               bus.in_ready, bus.ready_for_hashing, bus.window_reset, bus.is_insert, bus.window_id);
    end
    tests++;
    if (bus.window !== '0) begin
      fails++; $display("FAIL %s_window got %h required 0", tag, bus.window);
    end
  endtask

  task automatic model_clear();
    m_win = '0; m_cnt = 0; m_id = '0; m_ins = 1'b0; m_last = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    model_clear();
    @(posedge clk); #1;
  endtask

  task automatic test_overlap();
    win_t old;
    send_beat(acgt, 1'b1, 1'b0, 1'b1);
    tests++;
    if (bus.window_reset !== 1'b1) begin
      fails++; $display("FAIL wreset_pulse got %b required 1", bus.window_reset);
    end
    for (int i = 1; i < 32; i++) begin
      send_beat(acgt, 1'b0, 1'b0, 1'b1);
      if (i == 1) begin
        tests++;
        if (bus.window_reset !== 1'b0) begin
          fails++; $display("FAIL wreset_clear got %b required 0", bus.window_reset);
        end
      end
    end
    tests++;
    if (bus.window[0] !== 2'b00 || bus.window[WS-1] !== 2'b11) begin
      fails++; $display("FAIL win0_ends got %b/%b required 00/11", bus.window[0], bus.window[WS-1]);
    end
    check_window("win0");
    old = m_win;
    hash_done("win0");
    for (int i = 0; i < NEXT_BEATS; i++) send_beat(beat_t'($urandom), 1'b0, 1'b0, 1'b1);
    check_window("win1");
`ifdef WINDOW_ASSEMBLER_OVERLAP_EN
    tests++;
    if (bus.window[63:0] !== old[127:64]) begin
      fails++; $display("FAIL overlap got %h required %h", bus.window[63:0], old[127:64]);
    end
`endif
  endtask

  task automatic test_backpressure();
    bus.in_valid = 1'b1;
    bus.in_bases = beat_t'($urandom);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      tests++;
      if (bus.in_ready !== 1'b0 || bus.window !== m_win || bus.ready_for_hashing !== 1'b1) begin
        fails++;
        $display("FAIL backpressure cyc%0d rdy=%b rfh=%b required 0 1, window %h required %h",
                 i, bus.in_ready, bus.ready_for_hashing, bus.window, m_win);
      end
    end
    bus.in_valid = 1'b0;
    hash_done("bp");
  endtask

  task automatic test_partial();
    bus.hashing_is_done = 1'b1;
    @(posedge clk); #1;
    bus.hashing_is_done = 1'b0;
    tests++;
    if (bus.window_id !== m_id || bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL done_in_fill id=%0d rdy=%b required %0d 1", bus.window_id, bus.in_ready, m_id);
    end
    for (int i = 1; i <= 20; i++) begin
      send_beat(beat_t'($urandom), (i == 1), (i == 20), 1'b0);
      tests++;
      if (bus.ready_for_hashing !== 1'b0) begin
        fails++; $display("FAIL partial_rfh beat%0d got %b required 0", i, bus.ready_for_hashing);
      end
    end
    for (int i = 0; i < 32; i++) send_beat(beat_t'($urandom), (i == 0), 1'b0, 1'b0);
    check_window("partial_next");
    hash_done("partial_next");
  endtask

  task automatic test_id_wrap();
    logic [1:0] id_q[$];
    logic [1:0] exp_id;
    for (int w = 0; w < 5; w++) begin
      id_q.push_back(2'(w));
      for (int b = 0; b < ((w == 0) ? 32 : NEXT_BEATS); b++) begin
        bus2.in_valid = 1'b1; bus2.in_bases = beat_t'($urandom);
        bus2.in_seq_start = (w == 0 && b == 0); bus2.in_is_insert = 1'b1;
        @(posedge clk); #1;
        bus2.in_valid = 1'b0; bus2.in_seq_start = 1'b0;
      end
      exp_id = id_q.pop_front();
      tests++;
      if (bus2.ready_for_hashing !== 1'b1 || bus2.window_id !== exp_id) begin
        fails++; $display("FAIL id_wrap w%0d rfh=%b id=%0d required 1 %0d", w,
                          bus2.ready_for_hashing, bus2.window_id, exp_id);
      end
      bus2.hashing_is_done = 1'b1;
      @(posedge clk); #1;
      bus2.hashing_is_done = 1'b0;
    end
  endtask

  task automatic test_reset_mid_hold();
    for (int i = 0; i < 32; i++) send_beat(beat_t'($urandom), (i == 0), 1'b0, 1'b1);
    check_window("pre_rst");
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
    @(posedge clk); #1;
    tests++;
    if (bus.in_ready !== 1'b1 || bus.ready_for_hashing !== 1'b0) begin
      fails++; $display("FAIL post_rst rdy=%b rfh=%b required 1 0", bus.in_ready, bus.ready_for_hashing);
    end
  endtask

  initial begin
    acgt = {BASE_T, BASE_G, BASE_C, BASE_A};
    bus.in_valid = 1'b0; bus.in_bases = '0; bus.in_seq_start = 1'b0;
    bus.in_last = 1'b0; bus.in_is_insert = 1'b0; bus.hashing_is_done = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_bases = '0; bus2.in_seq_start = 1'b0;
    bus2.in_last = 1'b0; bus2.in_is_insert = 1'b0; bus2.hashing_is_done = 1'b0;
    model_clear();
    test_reset();
    test_overlap();
    test_backpressure();
    test_partial();
    test_id_wrap();
    test_reset_mid_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
